// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-serial framed program image loader for the CPU instruction RAM
module prog_loader #(
  parameter int         ADDR_W = 5,
  parameter logic [7:0] MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe_in,
  input  logic [7:0]        data_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // Image capacity; the count byte is 8 bits so the compare is done at 9 bits.
  localparam logic [8:0] CAP = 9'(1 << ADDR_W);

  state_t          state;
  logic            s1, s2, s3;
  logic            take;
  logic [8:0]      count_ext;
  logic [ADDR_W:0] addr_cnt;
  logic [8:0]      remaining;
  logic [7:0]      acc;

  // A byte is taken on the edge where the synchronised strobe has just risen.
  assign take = s2 & ~s3;

  // A count of zero stands for a full RAM image.
  assign count_ext = (data_in == 8'd0) ? CAP : {1'b0, data_in};

  // Two-flop synchroniser for the pin strobe plus one history flop for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Frame parser, RAM write port and CPU hold/status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      addr_cnt  <= '0;
      remaining <= 9'd0;
      acc       <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      if (take) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (data_in == MAGIC) begin
              state    <= S_COUNT;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              error    <= 1'b0;
              addr_cnt <= '0;
              acc      <= 8'd0;
            end
          end
          S_COUNT: begin
            if ({1'b0, data_in} > CAP) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              remaining <= count_ext;
              state     <= S_DATA;
            end
          end
          S_DATA: begin
            // The top address bit only sets after the final byte of a full image,
            // so the guard never drops a legal write; it prevents aliasing to 0.
            if (!addr_cnt[ADDR_W]) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_cnt[ADDR_W-1:0];
              mem_wdata <= data_in;
            end
            addr_cnt  <= addr_cnt + 1'b1;
            acc       <= acc ^ data_in;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) begin
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (data_in == acc) begin
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strobe_in;
  logic [7:0] data_in;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       error;

  prog_loader #(.ADDR_W(5), .MAGIC(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe_in (strobe_in),
    .data_in   (data_in),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse seen must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)",
                 mem_addr, mem_wdata, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // Present one byte; the write (if any) is expected 3 edges after strobe rises.
  task automatic send(input logic [7:0] b, input bit wr, input logic [4:0] a, input int hi);
    @(negedge clk);
    data_in   = b;
    strobe_in = 1'b1;
    if (wr) exp_q.push_back('{a, b, cyc + 3});
    repeat (hi) @(negedge clk);
    strobe_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic flags(input string tag, input logic h, input logic d, input logic e);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(h));
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    strobe_in = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(negedge clk);
    zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Non-magic byte in IDLE is ignored.
    send(8'h12, 0, 0, 3);
    flags("idle_ignore", 0, 0, 0);

    // Reset in the middle of DATA abandons the frame.
    send(8'hA5, 0, 0, 3);
    chk("magic_hold", 32'(cpu_hold), 32'd1);
    send(8'h03, 0, 0, 3);
    send(8'h11, 1, 0, 3);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    zero_outputs("mid_reset");
    rst_n = 1'b1;
    send(8'h22, 0, 0, 3);
    send(8'h12, 0, 0, 3);
    flags("post_reset", 0, 0, 0);

    // Good frame.
    send(8'hA5, 0, 0, 3);
    send(8'h03, 0, 0, 3);
    send(8'h11, 1, 0, 3);
    send(8'h22, 1, 1, 3);
    send(8'h44, 1, 2, 3);
    flags("good_pre_ck", 1, 0, 0);
    send(8'h77, 0, 0, 3);
    flags("good", 0, 1, 0);

    // Bad checksum, then a good retry.
    send(8'hA5, 0, 0, 3);
    send(8'h02, 0, 0, 3);
    send(8'h10, 1, 0, 3);
    send(8'h20, 1, 1, 3);
    send(8'h31, 0, 0, 3);
    flags("bad_ck", 1, 0, 1);
    send(8'hA5, 0, 0, 3);
    flags("retry_magic", 1, 0, 0);
    send(8'h01, 0, 0, 3);
    send(8'h5A, 1, 0, 3);
    send(8'h5A, 0, 0, 3);
    flags("retry", 0, 1, 0);

    // Count 0 means a full 32-byte image; XOR of 0..31 is 0.
    send(8'hA5, 0, 0, 3);
    send(8'h00, 0, 0, 3);
    for (int i = 0; i < 32; i++) send(8'(i), 1, 5'(i), 3);
    send(8'h00, 0, 0, 3);
    flags("full", 0, 1, 0);

    // Count above capacity fails at once with no writes.
    send(8'hA5, 0, 0, 3);
    send(8'h21, 0, 0, 3);
    flags("overcount", 1, 0, 1);

    // MAGIC is plain data inside DATA.
    send(8'hA5, 0, 0, 3);
    send(8'h02, 0, 0, 3);
    send(8'hA5, 1, 0, 3);
    send(8'h01, 1, 1, 3);
    send(8'hA4, 0, 0, 3);
    flags("magic_data", 0, 1, 0);

    // Strobe held high for 20 cycles yields one byte.
    send(8'hA5, 0, 0, 3);
    send(8'h02, 0, 0, 3);
    send(8'h33, 1, 0, 20);
    send(8'h00, 1, 1, 3);
    send(8'h33, 0, 0, 3);
    flags("held", 0, 1, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
